// File: rtl/tail_light_sequencer.sv
// Tail-light controller: sequential turn, hazard flash and brake patterns
// for LAMPS lamps per side, stepped by a built-in DIV-clock prescaler.
module tail_light_sequencer #(
   parameter int LAMPS = 3,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left_sw,
   input  logic             right_sw,
   input  logic             hazard_sw,
   input  logic             brake_sw,
   output logic [LAMPS-1:0] left_lamps,
   output logic [LAMPS-1:0] right_lamps,
   output logic [1:0]       mode
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int KW = $clog2(LAMPS + 1);
   localparam logic [LAMPS-1:0] ONES = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEFT   = 2'd1,
      RIGHT  = 2'd2,
      HAZARD = 2'd3
   } mode_t;

   mode_t            state;
   mode_t            state_nx;
   mode_t            req;
   logic [PW-1:0]    cnt;
   logic [KW-1:0]    k;
   logic [KW-1:0]    k_nx;
   logic             tick;
   logic [LAMPS-1:0] pat;
   logic [LAMPS-1:0] left_nx;
   logic [LAMPS-1:0] right_nx;

   assign tick = (cnt == PW'(DIV - 1));
   assign mode = state;

   always_comb begin
      req = IDLE;
      unique case (1'b1)
         hazard_sw | (left_sw & right_sw):     req = HAZARD;
         left_sw & ~right_sw & ~hazard_sw:     req = LEFT;
         right_sw & ~left_sw & ~hazard_sw:     req = RIGHT;
         default:                              req = IDLE;
      endcase
   end

   always_comb begin
      state_nx = state;
      k_nx     = k;
      if (tick) begin
         if (req != state) begin
            state_nx = req;
            k_nx     = '0;
         end else if (state == IDLE) begin
            k_nx = '0;
         end else begin
            k_nx = (k == KW'(LAMPS)) ? '0 : k + 1'b1;
         end
      end
   end

   // Lamps follow the next-state phase so they change on the tick edge itself.
   always_comb begin
      for (int i = 0; i < LAMPS; i++) begin
         pat[i] = (KW'(i) < k_nx);
      end
   end

   always_comb begin
      left_nx  = '0;
      right_nx = '0;
      unique case (state_nx)
         IDLE: begin
            if (brake_sw) begin
               left_nx  = ONES;
               right_nx = ONES;
            end
         end
         LEFT: begin
            left_nx = pat;
            if (brake_sw) right_nx = ONES;
         end
         RIGHT: begin
            right_nx = pat;
            if (brake_sw) left_nx = ONES;
         end
         HAZARD: begin
            left_nx  = {LAMPS{k_nx[0]}};
            right_nx = {LAMPS{k_nx[0]}};
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         k           <= '0;
         state       <= IDLE;
         left_lamps  <= '0;
         right_lamps <= '0;
      end else begin
         cnt         <= tick ? '0 : cnt + 1'b1;
         k           <= k_nx;
         state       <= state_nx;
         left_lamps  <= left_nx;
         right_lamps <= right_nx;
      end
   end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: three configurations driven in parallel
// and compared each clock against a step-count reference model.
module tb_tail_light_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic left_sw = 1'b0;
   logic right_sw = 1'b0;
   logic hazard_sw = 1'b0;
   logic brake_sw = 1'b0;

   logic [2:0] l0, r0, l2, r2;
   logic [3:0] l1, r1;
   logic [1:0] m0, m1, m2;

   always #5 clk = ~clk;

   tail_light_sequencer #(.LAMPS(3), .DIV(1)) u0 (
      .clk(clk), .reset(reset), .left_sw(left_sw), .right_sw(right_sw),
      .hazard_sw(hazard_sw), .brake_sw(brake_sw),
      .left_lamps(l0), .right_lamps(r0), .mode(m0));
   tail_light_sequencer #(.LAMPS(4), .DIV(1)) u1 (
      .clk(clk), .reset(reset), .left_sw(left_sw), .right_sw(right_sw),
      .hazard_sw(hazard_sw), .brake_sw(brake_sw),
      .left_lamps(l1), .right_lamps(r1), .mode(m1));
   tail_light_sequencer #(.LAMPS(3), .DIV(4)) u2 (
      .clk(clk), .reset(reset), .left_sw(left_sw), .right_sw(right_sw),
      .hazard_sw(hazard_sw), .brake_sw(brake_sw),
      .left_lamps(l2), .right_lamps(r2), .mode(m2));

   logic [9:0] obs [3];
   assign obs[0] = {1'b0, l0, 1'b0, r0, m0};
   assign obs[1] = {l1, r1, m1};
   assign obs[2] = {1'b0, l2, 1'b0, r2, m2};

   int lmp [3] = '{3, 4, 3};
   int dv  [3] = '{1, 1, 4};
   int cyc [3];
   int md  [3];
   int n   [3];
   logic [9:0] ev [3];

   int nchk = 0;
   int nfail = 0;

   // Expected outputs from the mode and the number of steps spent in it.
   function automatic logic [9:0] calc(int i, logic brk);
      int ph;
      logic [3:0] ones, pat, l, r;
      ph   = n[i] % (lmp[i] + 1);
      ones = 4'((1 << lmp[i]) - 1);
      pat  = 4'((1 << ph) - 1);
      l = '0;
      r = '0;
      case (md[i])
         0: if (brk) begin l = ones; r = ones; end
         1: begin l = pat; r = brk ? ones : 4'd0; end
         2: begin r = pat; l = brk ? ones : 4'd0; end
         default: begin l = (ph % 2 == 1) ? ones : 4'd0; r = l; end
      endcase
      return {l, r, 2'(md[i])};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 0; md[i] = 0; n[i] = 0; ev[i] = '0;
      end
   endtask

   task automatic step();
      int rq;
      @(posedge clk);
      if (!reset) begin
         rq = (hazard_sw || (left_sw && right_sw)) ? 3 :
              left_sw ? 1 : right_sw ? 2 : 0;
         for (int i = 0; i < 3; i++) begin
            cyc[i]++;
            if (cyc[i] % dv[i] == 0) begin
               if (rq != md[i]) begin md[i] = rq; n[i] = 0; end
               else if (md[i] != 0) n[i]++;
            end
            ev[i] = calc(i, brake_sw);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         nchk++;
         if (obs[i] !== ev[i]) begin
            nfail++;
            $display("FAIL reset inst%0d got %b exp %b", i, obs[i], ev[i]);
         end
      end
      repeat (2) step();
      for (int i = 0; i < 3; i++) begin
         nchk++;
         if (obs[i] !== 10'd0) begin
            nfail++;
            $display("FAIL reset_hold inst%0d got %b exp 0", i, obs[i]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_left_sequence();
      logic [2:0] tbl [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
      left_sw = 1'b1;
      for (int c = 0; c < 14; c++) begin
         step();
         if (c < 6) begin
            nchk++;
            if (l0 !== tbl[c] || r0 !== 3'b000 || m0 !== 2'd1) begin
               nfail++;
               $display("FAIL left_table c%0d got l=%b r=%b m=%0d exp l=%b r=000 m=1",
                        c, l0, r0, m0, tbl[c]);
            end
         end
         for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[i] !== ev[i]) begin
               nfail++;
               $display("FAIL left inst%0d got %b exp %b", i, obs[i], ev[i]);
            end
         end
      end
   endtask

   task automatic test_hazard();
      left_sw = 1'b0; hazard_sw = 1'b1; brake_sw = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[i] !== ev[i]) begin
               nfail++;
               $display("FAIL hazard inst%0d got %b exp %b", i, obs[i], ev[i]);
            end
         end
      end
      hazard_sw = 1'b0; brake_sw = 1'b0;
   endtask

   task automatic test_brake();
      right_sw = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c == 7) brake_sw = 1'b1;
         if (c == 12) right_sw = 1'b0;
         if (c == 17) brake_sw = 1'b0;
         step();
         for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[i] !== ev[i]) begin
               nfail++;
               $display("FAIL brake inst%0d c%0d got %b exp %b", i, c, obs[i], ev[i]);
            end
         end
      end
   endtask

   task automatic test_mode_change();
      int b;
      left_sw = 1'b1;
      b = 0;
      do begin step(); b++; end while (!(md[0] == 1 && n[0] % 4 == 2) && b < 40);
      nchk++;
      if (b >= 40) begin
         nfail++;
         $display("FAIL mode_change_wait got timeout exp k=2");
      end
      left_sw = 1'b0; right_sw = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[i] !== ev[i]) begin
               nfail++;
               $display("FAIL mode_change inst%0d c%0d got %b exp %b", i, c, obs[i], ev[i]);
            end
         end
      end
      right_sw = 1'b0;
   endtask

   task automatic test_reset_mid();
      int b;
      left_sw = 1'b1;
      b = 0;
      do begin step(); b++; end while (!(md[0] == 1 && n[0] % 4 == 3) && b < 40);
      nchk++;
      if (b >= 40) begin
         nfail++;
         $display("FAIL reset_mid_wait got timeout exp k=3");
      end
      #2 reset = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         nchk++;
         if (obs[i] !== ev[i]) begin
            nfail++;
            $display("FAIL reset_mid inst%0d got %b exp %b", i, obs[i], ev[i]);
         end
      end
      step();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[i] !== ev[i]) begin
               nfail++;
               $display("FAIL restart inst%0d c%0d got %b exp %b", i, c, obs[i], ev[i]);
            end
         end
      end
      left_sw = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0] sw;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(7) == 0) begin
            sw = 3'($urandom_range(7));
            left_sw = sw[0]; right_sw = sw[1];
            hazard_sw = sw[2] & ($urandom_range(1) == 0);
         end
         if ($urandom_range(5) == 0) brake_sw = ~brake_sw;
         step();
         for (int i = 0; i < 3; i++) begin
            nchk++;
            if (obs[i] !== ev[i]) begin
               nfail++;
               $display("FAIL random inst%0d c%0d got %b exp %b", i, c, obs[i], ev[i]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      #2;
      test_reset();
      test_left_sequence();
      test_hazard();
      test_brake();
      test_mode_change();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
